// File: rtl/tile_gen_if.sv
// Lane-pattern bus between the tile generator and its consumer.
// The master side is the generator; the slave side owns the start button.
interface tile_gen_if;
   logic       start_n;
   logic [2:0] data;
   logic       row_strobe;
   logic [7:0] row_cnt;
   logic       busy;
   logic       done;

   modport master (
      input  start_n,
      output data,
      output row_strobe,
      output row_cnt,
      output busy,
      output done
   );

   modport slave (
      output start_n,
      input  data,
      input  row_strobe,
      input  row_cnt,
      input  busy,
      input  done
   );
endinterface

// File: rtl/tile_gen.sv
// Tile generator: presents a pseudo-random, never-empty 3-lane row pattern once per
// row window for ROWS rows, then idles in DONE until the start button is pressed again.
module tile_gen #(
   parameter int          WINDOW = 1000,
   parameter int          ROWS   = 32,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic       div_clk,
   input  logic       rst,
   tile_gen_if.master io
);

   localparam logic [1:0]  IDLE = 2'd0;
   localparam logic [1:0]  RUN  = 2'd1;
   localparam logic [1:0]  DONE = 2'd2;

   // An all-zero LFSR would lock up, so a zero seed falls back to the default.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam logic [31:0] WIN_LAST = 32'(WINDOW);
   localparam logic [7:0]  ROW_LAST = 8'(ROWS);

   function automatic logic [2:0] lane_map(input logic [2:0] raw);
      return (raw == 3'b000) ? 3'b010 : raw;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   logic [1:0]  state;
   logic [31:0] cnt;
   logic [15:0] lfsr;
   logic [2:0]  data_p0;
   logic        vld_p0;
   logic [7:0]  row_cnt;
   logic        win_end;
   logic        last_row;

   assign win_end  = (cnt == WIN_LAST);
   assign last_row = (row_cnt >= ROW_LAST);

   always_ff @(posedge div_clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 32'd0;
         lfsr    <= SEED_EFF;
         data_p0 <= 3'b000;
         vld_p0  <= 1'b0;
         row_cnt <= 8'd0;
      end else begin
         vld_p0 <= 1'b0;
         case (state)
            IDLE, DONE: begin
               data_p0 <= 3'b000;
               cnt     <= 32'd0;
               if (!io.start_n) begin
                  // A new game loads its first row on the same edge that sees the button.
                  state   <= RUN;
                  data_p0 <= lane_map(lfsr[2:0]);
                  lfsr    <= lfsr_next(lfsr);
                  row_cnt <= 8'd1;
                  vld_p0  <= 1'b1;
               end
            end
            RUN: begin
               if (!win_end) begin
                  cnt <= cnt + 32'd1;
               end else if (!last_row) begin
                  data_p0 <= lane_map(lfsr[2:0]);
                  lfsr    <= lfsr_next(lfsr);
                  cnt     <= 32'd0;
                  row_cnt <= row_cnt + 8'd1;
                  vld_p0  <= 1'b1;
               end else begin
                  state   <= DONE;
                  data_p0 <= 3'b000;
                  cnt     <= 32'd0;
               end
            end
            default: begin
               state   <= IDLE;
               data_p0 <= 3'b000;
               cnt     <= 32'd0;
            end
         endcase
      end
   end

   assign io.data       = data_p0;
   assign io.row_strobe = vld_p0;
   assign io.row_cnt    = row_cnt;
   assign io.busy       = (state == RUN);
   assign io.done       = (state == DONE);

endmodule

// File: tb/tb_tile_gen.sv
// Bench for tile_gen: four differently parameterised instances checked every cycle
// against an elapsed-time game model, plus directed checks of the known row sequence.
module tb_tile_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic st_n [4];

   always #5 clk = ~clk;

   tile_gen_if if0 ();
   tile_gen_if if1 ();
   tile_gen_if if2 ();
   tile_gen_if if3 ();

   assign if0.start_n = st_n[0];
   assign if1.start_n = st_n[1];
   assign if2.start_n = st_n[2];
   assign if3.start_n = st_n[3];

   tile_gen #(.WINDOW(1000), .ROWS(32), .SEED(16'hACE1)) u0 (.div_clk(clk), .rst(rst), .io(if0.master));
   tile_gen #(.WINDOW(3),    .ROWS(2),  .SEED(16'hACE1)) u1 (.div_clk(clk), .rst(rst), .io(if1.master));
   tile_gen #(.WINDOW(5),    .ROWS(4),  .SEED(16'h0008)) u2 (.div_clk(clk), .rst(rst), .io(if2.master));
   tile_gen #(.WINDOW(7),    .ROWS(5),  .SEED(16'h0000)) u3 (.div_clk(clk), .rst(rst), .io(if3.master));

   logic [2:0] o_data [4];
   logic       o_stb  [4];
   logic [7:0] o_rc   [4];
   logic       o_busy [4];
   logic       o_done [4];

   assign o_data[0] = if0.data;  assign o_stb[0] = if0.row_strobe;  assign o_rc[0] = if0.row_cnt;
   assign o_data[1] = if1.data;  assign o_stb[1] = if1.row_strobe;  assign o_rc[1] = if1.row_cnt;
   assign o_data[2] = if2.data;  assign o_stb[2] = if2.row_strobe;  assign o_rc[2] = if2.row_cnt;
   assign o_data[3] = if3.data;  assign o_stb[3] = if3.row_strobe;  assign o_rc[3] = if3.row_cnt;
   assign o_busy[0] = if0.busy;  assign o_done[0] = if0.done;
   assign o_busy[1] = if1.busy;  assign o_done[1] = if1.done;
   assign o_busy[2] = if2.busy;  assign o_done[2] = if2.done;
   assign o_busy[3] = if3.busy;  assign o_done[3] = if3.done;

   int          P_W [4] = '{1000, 3, 5, 7};
   int          P_R [4] = '{32, 2, 4, 5};
   logic [15:0] P_S [4] = '{16'hACE1, 16'hACE1, 16'h0008, 16'h0000};

   // Model: mode 0 = waiting for first game, 1 = game in progress, 2 = game over.
   int          m_mode [4];
   int          m_e    [4];
   int          m_rows [4];
   logic [15:0] m_lf   [4];
   logic [2:0]  m_data [4];
   logic        m_stb  [4];

   int ntests = 0;
   int nfail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int i);
      m_mode[i] = 0;
      m_e[i]    = 0;
      m_rows[i] = 0;
      m_lf[i]   = (P_S[i] == 16'h0000) ? 16'hACE1 : P_S[i];
      m_data[i] = 3'b000;
      m_stb[i]  = 1'b0;
   endtask

   task automatic model_new_row(input int i);
      m_data[i] = (m_lf[i][2:0] == 3'b000) ? 3'b010 : m_lf[i][2:0];
      m_lf[i]   = {m_lf[i][14:0], m_lf[i][15] ^ m_lf[i][13] ^ m_lf[i][12] ^ m_lf[i][10]};
      m_stb[i]  = 1'b1;
      m_rows[i] = m_rows[i] + 1;
   endtask

   // Row k (0-based) of a game is shown from cycle k*(W+1) after the start edge;
   // the game is over at cycle ROWS*(W+1).
   task automatic model_step(input int i);
      m_stb[i] = 1'b0;
      if (!rst) begin
         model_reset(i);
      end else if (m_mode[i] != 1) begin
         if (!st_n[i]) begin
            m_mode[i] = 1;
            m_e[i]    = 0;
            m_rows[i] = 0;
            model_new_row(i);
         end
      end else begin
         m_e[i] = m_e[i] + 1;
         if (m_e[i] % (P_W[i] + 1) == 0) begin
            if (m_e[i] / (P_W[i] + 1) < P_R[i]) begin
               model_new_row(i);
            end else begin
               m_mode[i] = 2;
               m_data[i] = 3'b000;
            end
         end
      end
   endtask

   task automatic cmp_all();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("data%0d", i), 32'(o_data[i]), 32'(m_data[i]));
         chk($sformatf("strobe%0d", i), 32'(o_stb[i]), 32'(m_stb[i]));
         chk($sformatf("row_cnt%0d", i), 32'(o_rc[i]), 32'(m_rows[i]));
         chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(m_mode[i] == 1));
         chk($sformatf("done%0d", i), 32'(o_done[i]), 32'(m_mode[i] == 2));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 4; i++) model_step(i);
      @(negedge clk);
      cmp_all();
   endtask

   task automatic run(input int n, input bit rnd0, input bit rnd3);
      for (int k = 0; k < n; k++) begin
         tick();
         if (rnd0) st_n[0] = 1'($urandom_range(0, 1));
         if (rnd3) st_n[3] = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         st_n[i] = 1'b1;
         model_reset(i);
      end
      #1 rst = 1'b0;
      #1 cmp_all();
      run(3, 1'b0, 1'b0);
      rst = 1'b1;

      // Idle with the button released.
      run(5000, 1'b0, 1'b0);

      // Start the first three instances together.
      st_n[0] = 1'b0; st_n[1] = 1'b0; st_n[2] = 1'b0;
      tick();
      st_n[0] = 1'b1; st_n[1] = 1'b1; st_n[2] = 1'b1;
      chk("first_data", 32'(o_data[0]), 32'h1);
      chk("first_strobe", 32'(o_stb[0]), 32'h1);
      chk("first_rowcnt", 32'(o_rc[0]), 32'h1);
      chk("seed8_data", 32'(o_data[2]), 32'h2);

      run(4, 1'b0, 1'b1);
      chk("small_strobe2", 32'(o_stb[1]), 32'h1);
      chk("small_rowcnt2", 32'(o_rc[1]), 32'h2);
      run(4, 1'b0, 1'b1);
      chk("small_done", 32'(o_done[1]), 32'h1);
      chk("small_data0", 32'(o_data[1]), 32'h0);

      run(993, 1'b1, 1'b1);
      chk("second_data", 32'(o_data[0]), 32'h3);
      chk("second_rowcnt", 32'(o_rc[0]), 32'h2);
      chk("second_strobe", 32'(o_stb[0]), 32'h1);

      // Restart the finished small instance; the LFSR carries on from the old game.
      st_n[1] = 1'b0;
      tick();
      st_n[1] = 1'b1;
      chk("restart_rowcnt", 32'(o_rc[1]), 32'h1);
      chk("restart_data", 32'(o_data[1]), 32'h7);
      chk("restart_differs", 32'(o_data[1] != 3'b001), 32'h1);

      // Reach the middle of row 3 with the button bouncing, then reset between edges.
      run(1500, 1'b1, 1'b1);
      chk("row3_rowcnt", 32'(o_rc[0]), 32'h3);
      st_n[0] = 1'b1;
      #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) model_reset(i);
      #1;
      chk("arst_data", 32'(o_data[0]), 32'h0);
      chk("arst_rowcnt", 32'(o_rc[0]), 32'h0);
      chk("arst_busy", 32'(o_busy[0]), 32'h0);
      cmp_all();
      tick();
      rst = 1'b1;
      run(2, 1'b0, 1'b1);

      st_n[0] = 1'b0;
      tick();
      st_n[0] = 1'b1;
      chk("again_first", 32'(o_data[0]), 32'h1);
      chk("again_rowcnt1", 32'(o_rc[0]), 32'h1);
      run(1001, 1'b0, 1'b1);
      chk("again_second", 32'(o_data[0]), 32'h3);
      chk("again_rowcnt2", 32'(o_rc[0]), 32'h2);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/tile_gen.md
TILE_GEN -- requirements
Module: tile_gen

Interface
REQ-001 Parameter WINDOW, default 1000: last value of the row-window counter; one row period is WINDOW+1 cycles.
REQ-002 Parameter ROWS, default 32: number of rows per game, legal range 1..255.
REQ-003 Parameter SEED, default 16'hACE1: LFSR value loaded at reset; SEED==0 SHALL be replaced by 16'hACE1.
REQ-004 div_clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 start_n  input  1  start button, active-low, sampled on every div_clk edge.
REQ-007 data  output  3  lane pattern for the current row; bit2 = lane 1, bit0 = lane 3; registered.
REQ-008 row_strobe  output  1  one-cycle pulse in the cycle a new row first appears on data.
REQ-009 row_cnt  output  8  number of rows presented in the current game.
REQ-010 busy  output  1  high in state RUN.
REQ-011 done  output  1  high in state DONE.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE, encoded in 2 bits.
REQ-013 In IDLE: data=0, cnt held at 0, row_cnt held; start_n==0 SHALL cause RUN on the next edge, with the first row loaded on that same edge.
REQ-014 Row load: data <= MAP(lfsr[2:0]); lfsr <= next(lfsr); cnt <= 0; row_cnt <= row_cnt+1; row_strobe <= 1; start of game sets row_cnt to 1.
REQ-015 MAP: 3'b000 -> 3'b010; all other values pass through unchanged; data is therefore never 0 in RUN.
REQ-016 next(l) = {l[14:0], l[15]^l[13]^l[12]^l[10]}; the LFSR SHALL advance only on a row load.
REQ-017 RUN: cnt (32-bit) SHALL increment by 1 each cycle while cnt != WINDOW; data is stable between loads.
REQ-018 RUN with cnt==WINDOW and row_cnt<ROWS: row load on that edge.
REQ-019 RUN with cnt==WINDOW and row_cnt==ROWS: next state DONE, data <= 0, cnt <= 0, no row_strobe.
REQ-020 In RUN, start_n SHALL be ignored.
REQ-021 In DONE: data=0; start_n==0 SHALL start a new game directly (RUN, row load, row_cnt=1), with the LFSR continuing from its current value and not re-seeded.
REQ-022 row_strobe SHALL be 0 in every cycle except a row-load cycle.
REQ-023 Row period: the data change SHALL coincide with a consumer window counter that counts 0..WINDOW and samples data on the edge after reaching WINDOW.
REQ-024 row_cnt SHALL never exceed ROWS.

Reset
REQ-025 While rst==0, all state SHALL clear immediately: state=IDLE, data=0, row_strobe=0, row_cnt=0, cnt=0, lfsr=SEED (or 16'hACE1).
REQ-026 Reset asserted mid-row or in DONE SHALL abort the game; after release the block SHALL wait in IDLE for start_n.

Verification
REQ-027 Reset, start_n held 1 for 5000 cycles -> data=0, busy=0, row_strobe never 1.
REQ-028 Default parameters; start_n=0 for one cycle -> next edge: data=3'b001, row_strobe=1, row_cnt=1; after 1001 more cycles: data=3'b011 (lfsr 16'h59C3), row_cnt=2.
REQ-029 ROWS=2, WINDOW=3 -> two strobes 4 cycles apart; done=1 four cycles after the second strobe; data=0.
REQ-030 SEED=16'h0008 -> first row data=3'b010 (MAP of 000).
REQ-031 rst pulsed low at cnt=500 of row 3 -> outputs clear asynchronously; restart reproduces the 001, 011 sequence.
REQ-032 start_n toggling throughout RUN -> row timing unchanged; restart from DONE -> row_cnt=1 and first data differs from the first row of the previous game.
